// File: rtl/led_matrix_scan_driver_pkg.sv
// Shared types, default sizes and pin-polarity helper for the LED matrix scan driver.
package led_matrix_scan_driver_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    localparam int unsigned DEF_ROWS = 8;
    localparam int unsigned DEF_COLS = 8;

    // Map a logical "1 = lit" vector to pin levels; callers cast to their own width.
    function automatic logic [63:0] apply_pol(input logic [63:0] bits, input logic act_low);
        return act_low ? ~bits : bits;
    endfunction

endpackage

// File: rtl/led_matrix_scan_driver_if.sv
// Frame-buffer write port from the column PIO plus the swap request/status pair.
interface led_matrix_scan_driver_if
    import led_matrix_scan_driver_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS
) ();
    localparam int unsigned ROW_W = $clog2(ROWS);

    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COLS-1:0]  wr_data;
    logic             frame_swap;
    logic             swap_pending;

    modport master (output wr_en, output wr_row, output wr_data, output frame_swap,
                    input swap_pending);
    modport slave  (input wr_en, input wr_row, input wr_data, input frame_swap,
                    output swap_pending);
endinterface

// File: rtl/led_matrix_scan_driver_tick.sv
// Scan-tick prescaler: one-cycle tick every PRESCALE enabled clocks, parked at 0 when disabled.
module led_matrix_scan_driver_tick #(
    parameter int unsigned PRESCALE = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick_c
);
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] cnt;

    // Free-running divider, cleared whenever scanning is disabled.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(PRESCALE - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_c = en && (cnt == CNT_W'(PRESCALE - 1));
endmodule

// File: rtl/led_matrix_scan_driver.sv
// Double-buffered row-scan driver: blank gap, then one lit row; buffers swap only at frame end.
module led_matrix_scan_driver
    import led_matrix_scan_driver_pkg::*;
#(
    parameter int unsigned ROWS        = DEF_ROWS,
    parameter int unsigned COLS        = DEF_COLS,
    parameter int unsigned PRESCALE    = 5000,
    parameter int unsigned ON_TICKS    = 16,
    parameter int unsigned BLANK_TICKS = 1,
    parameter bit          ROW_ACT_LOW = 1'b1,
    parameter bit          COL_ACT_LOW = 1'b0,
    localparam int unsigned ROW_W      = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    led_matrix_scan_driver_if.slave  bus,
    output logic [ROWS-1:0]          row_sel,
    output logic [COLS-1:0]          col_drv,
    output logic [ROW_W-1:0]         cur_row,
    output logic                     frame_done
);
    localparam int unsigned TICK_W = $clog2(ON_TICKS + BLANK_TICKS + 1);

    scan_state_t       state, state_nx;
    logic [ROW_W-1:0]  row, row_nx;
    logic [TICK_W-1:0] tcnt, tcnt_nx;
    logic              tick_c;
    logic              frame_end_c;
    logic              enter_on_c;
    logic              lit_c;

    logic [COLS-1:0]   mem [2][ROWS];
    logic              front;
    logic              pending;
    logic [COLS-1:0]   col_lat;

    led_matrix_scan_driver_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (enable),
        .tick_c (tick_c)
    );

    // Scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK;
            row   <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            tcnt  <= tcnt_nx;
        end
    end

    // Next-state: count ticks per phase, advance row at ON end, restart at row 0 when disabled.
    always_comb begin
        state_nx    = state;
        row_nx      = row;
        tcnt_nx     = tcnt;
        frame_end_c = 1'b0;
        enter_on_c  = 1'b0;
        if (!enable) begin
            state_nx = BLANK;
            row_nx   = '0;
            tcnt_nx  = '0;
        end else if (tick_c) begin
            case (state)
                BLANK: begin
                    if (tcnt == TICK_W'(BLANK_TICKS - 1)) begin
                        state_nx   = ON;
                        tcnt_nx    = '0;
                        enter_on_c = 1'b1;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
                ON: begin
                    if (tcnt == TICK_W'(ON_TICKS - 1)) begin
                        state_nx = BLANK;
                        tcnt_nx  = '0;
                        if (row == ROW_W'(ROWS - 1)) begin
                            row_nx      = '0;
                            frame_end_c = 1'b1;
                        end else begin
                            row_nx = row + 1'b1;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
                default: state_nx = BLANK;
            endcase
        end
    end

    // Frame buffers: software only ever writes the back buffer; out-of-range rows are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (bus.wr_en && (32'(bus.wr_row) < ROWS)) begin
            mem[!front][bus.wr_row] <= bus.wr_data;
        end
    end

    // Front select and pending swap; a request on the frame-end cycle swaps immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            front   <= 1'b0;
            pending <= 1'b0;
        end else if (frame_end_c && (pending || bus.frame_swap)) begin
            front   <= ~front;
            pending <= 1'b0;
        end else if (bus.frame_swap) begin
            pending <= 1'b1;
        end
    end

    // Column word is frozen on entry to ON so a mid-row swap cannot change a lit row.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_lat <= '0;
        end else if (enter_on_c) begin
            col_lat <= mem[front][row];
        end
    end

    assign lit_c = enable && (state == ON);

    // Registered pin drivers; dark whenever blanking or disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel    <= ROWS'(apply_pol(64'd0, ROW_ACT_LOW));
            col_drv    <= COLS'(apply_pol(64'd0, COL_ACT_LOW));
            frame_done <= 1'b0;
        end else begin
            row_sel    <= ROWS'(apply_pol(lit_c ? (64'd1 << row) : 64'd0, ROW_ACT_LOW));
            col_drv    <= COLS'(apply_pol(lit_c ? 64'(col_lat) : 64'd0, COL_ACT_LOW));
            frame_done <= frame_end_c;
        end
    end

    assign cur_row          = row;
    assign bus.swap_pending = pending;
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Scoreboard bench for led_matrix_scan_driver: time-based reference model, queued expectations.
module tb_led_matrix_scan_driver;
    localparam int P    = 2;
    localparam int ONT  = 3;
    localparam int BLK  = 1;
    localparam int RP   = ONT + BLK;
    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef struct {
        logic [7:0] rs;
        logic [7:0] cd;
        logic [2:0] cr;
        logic       sp;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] row_sel;
    logic [7:0] col_drv;
    logic [2:0] cur_row;
    logic       frame_done;

    led_matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_matrix_scan_driver #(
        .ROWS(ROWS), .COLS(COLS), .PRESCALE(P), .ON_TICKS(ONT), .BLANK_TICKS(BLK),
        .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .row_sel    (row_sel),
        .col_drv    (col_drv),
        .cur_row    (cur_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference model: t = enabled clocks since the scan last restarted.
    int         t = 0;
    logic       m_front = 1'b0;
    logic       m_pending = 1'b0;
    logic [7:0] m_mem [2][ROWS];
    logic [7:0] m_latch = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_row(input int tt);
        return ((tt / P) / RP) % ROWS;
    endfunction

    function automatic bit m_on(input int tt);
        return ((tt / P) % RP) >= BLK;
    endfunction

    function automatic bit next_is_frame_end();
        return (t % P == P - 1) && ((t / P) % RP == RP - 1) && (m_row(t) == ROWS - 1);
    endfunction

    // Drive one cycle of inputs, advance the model across the coming edge, queue the result.
    task automatic step(input logic en, input logic rst, input logic wen,
                        input logic [2:0] wrow, input logic [7:0] wdata, input logic swp);
        exp_t e;
        bit   tick, fe, on;
        int   row, ph;
        @(negedge clk);
        enable         = en;
        reset          = rst;
        bus.wr_en      = wen;
        bus.wr_row     = wrow;
        bus.wr_data    = wdata;
        bus.frame_swap = swp;
        if (rst) begin
            t = 0;
            m_front = 1'b0;
            m_pending = 1'b0;
            m_latch = 8'h00;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++) m_mem[b][r] = 8'h00;
            e = '{rs: 8'h00, cd: 8'h00, cr: 3'd0, sp: 1'b0, fd: 1'b0};
        end else begin
            row  = m_row(t);
            ph   = (t / P) % RP;
            on   = m_on(t);
            e.rs = (en && on) ? 8'(1 << row) : 8'h00;
            e.cd = (en && on) ? m_latch : 8'h00;
            tick = en && (t % P == P - 1);
            fe   = tick && (ph == RP - 1) && (row == ROWS - 1);
            if (tick && ph == BLK - 1) m_latch = m_mem[m_front][row];
            if (wen && int'(wrow) < ROWS) m_mem[!m_front][wrow] = wdata;
            if (fe && (m_pending || swp)) begin
                m_front   = !m_front;
                m_pending = 1'b0;
            end else if (swp) begin
                m_pending = 1'b1;
            end
            e.fd = fe;
            t    = en ? t + 1 : 0;
            e.cr = 3'(m_row(t));
            e.sp = m_pending;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    // Monitor: every clock the DUT presents a new output set; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("row_sel", 32'(row_sel), 32'(e.rs));
                chk("col_drv", 32'(col_drv), 32'(e.cd));
                chk("cur_row", 32'(cur_row), 32'(e.cr));
                chk("swap_pending", 32'(bus.swap_pending), 32'(e.sp));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    end

    initial begin
        int guard;
        enable = 1'b0;
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_row = 3'd0;
        bus.wr_data = 8'h00;
        bus.frame_swap = 1'b0;

        // Reset, then plain scanning of an all-dark frame for two frames.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(130, 1'b1);

        // Load row 3 into the back buffer, request a swap, watch it apply at frame end.
        step(1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(140, 1'b1);

        // Swap requested exactly on the frame-end cycle: immediate, no pending phase.
        for (int r = 0; r < ROWS; r++) step(1'b1, 1'b0, 1'b1, 3'(r), 8'($urandom), 1'b0);
        guard = 0;
        while (!next_is_frame_end() && guard < 200) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("frame_end_reached", 32'(guard < 200), 32'd1);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(70, 1'b1);

        // Back-buffer writes while displaying: visible only after the next swap.
        for (int i = 0; i < 70; i++)
            step(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(70, 1'b1);

        // Disable in the middle of row 5's ON phase with a swap pending, then re-enable.
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        guard = 0;
        while (!(m_row(t) == 5 && m_on(t) && ((t / P) % RP) == BLK + 1) && guard < 200) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("row5_on_reached", 32'(guard < 200), 32'd1);
        idle(5, 1'b0);
        idle(80, 1'b1);

        // Reset with a swap pending: everything back to dark and buffer 0.
        step(1'b1, 1'b0, 1'b1, 3'd2, 8'h3C, 1'b1);
        idle(10, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(70, 1'b1);

        // Randomised traffic: enable drops, writes, swap requests, occasional reset.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 29) != 0, $urandom_range(0, 799) == 0,
                 $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 59) == 0);

        idle(2, 1'b1);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
